// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a handshaked data-memory port, stall,
// branch/jump redirect and the MEM/WB pipeline register.
`default_nettype none

module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Jump_in,
  input  logic [31:0] jump_addr_in,
  input  logic [31:0] branch_addr_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] reg_read_data_2_in,
  input  logic        ALU_zero_in,
  input  logic [4:0]  EX_MEM_RegisterRd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        PCSrc_out,
  output logic [31:0] PC_target_out,
  output logic        Flush_out,
  output logic        Stall_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] read_data_out,
  output logic [31:0] ALU_result_out,
  output logic [4:0]  MEM_WB_RegisterRd_out
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  // Writeback fields of the in-flight memory instruction, captured at issue.
  logic        rw_q;
  logic        mtr_q;
  logic [4:0]  rd_q;
  logic        wb_rw_q;
  logic        wb_mtr_q;
  logic [31:0] wb_rdata_q;
  logic [31:0] wb_alu_q;
  logic [4:0]  wb_rd_q;
  logic        access;

  assign access = MemRead_in | MemWrite_in;

  always_comb begin
    Stall_out     = 1'b0;
    PCSrc_out     = 1'b0;
    PC_target_out = 32'h0;
    if (state_q == IDLE) begin
      Stall_out = access;
      if (!access) begin
        if (Jump_in) begin
          PCSrc_out     = 1'b1;
          PC_target_out = jump_addr_in;
        end else if (Branch_in && ALU_zero_in) begin
          PCSrc_out     = 1'b1;
          PC_target_out = branch_addr_in;
        end
      end
    end else begin
      Stall_out = ~mem_ack;
    end
  end

  assign Flush_out = PCSrc_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rw_q        <= 1'b0;
      mtr_q       <= 1'b0;
      rd_q        <= 5'h0;
      wb_rw_q     <= 1'b0;
      wb_mtr_q    <= 1'b0;
      wb_rdata_q  <= 32'h0;
      wb_alu_q    <= 32'h0;
      wb_rd_q     <= 5'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            state_q     <= WAIT;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= ALU_result_in;
            mem_wdata_q <= reg_read_data_2_in;
            mem_we_q    <= MemWrite_in;
            rw_q        <= RegWrite_in;
            mtr_q       <= MemtoReg_in;
            rd_q        <= EX_MEM_RegisterRd_in;
            wb_rw_q     <= 1'b0;
            wb_mtr_q    <= 1'b0;
          end else begin
            wb_rw_q    <= RegWrite_in;
            wb_mtr_q   <= MemtoReg_in;
            wb_alu_q   <= ALU_result_in;
            wb_rd_q    <= EX_MEM_RegisterRd_in;
            wb_rdata_q <= 32'h0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            wb_rw_q    <= rw_q;
            wb_mtr_q   <= mtr_q;
            wb_alu_q   <= mem_addr_q;
            wb_rd_q    <= rd_q;
            // A combined read+write issues as a store, so no load data.
            wb_rdata_q <= mem_we_q ? 32'h0 : mem_rdata;
          end else begin
            wb_rw_q  <= 1'b0;
            wb_mtr_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req               = mem_req_q;
  assign mem_we                = mem_we_q;
  assign mem_addr              = mem_addr_q;
  assign mem_wdata             = mem_wdata_q;
  assign RegWrite_out          = wb_rw_q;
  assign MemtoReg_out          = wb_mtr_q;
  assign read_data_out         = wb_rdata_q;
  assign ALU_result_out        = wb_alu_q;
  assign MEM_WB_RegisterRd_out = wb_rd_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: reset, ALU/load/store, redirect, reset mid-access.
`default_nettype none

module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Jump_in;
  logic [31:0] jump_addr_in, branch_addr_in, ALU_result_in, reg_read_data_2_in;
  logic        ALU_zero_in;
  logic [4:0]  EX_MEM_RegisterRd_in;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        PCSrc_out, Flush_out, Stall_out, RegWrite_out, MemtoReg_out;
  logic [31:0] PC_target_out, read_data_out, ALU_result_out;
  logic [4:0]  MEM_WB_RegisterRd_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Jump_in(Jump_in),
    .jump_addr_in(jump_addr_in), .branch_addr_in(branch_addr_in),
    .ALU_result_in(ALU_result_in), .reg_read_data_2_in(reg_read_data_2_in),
    .ALU_zero_in(ALU_zero_in), .EX_MEM_RegisterRd_in(EX_MEM_RegisterRd_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .PCSrc_out(PCSrc_out), .PC_target_out(PC_target_out), .Flush_out(Flush_out),
    .Stall_out(Stall_out), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .read_data_out(read_data_out), .ALU_result_out(ALU_result_out),
    .MEM_WB_RegisterRd_out(MEM_WB_RegisterRd_out)
  );

  task automatic set_nop();
    RegWrite_in = 0; MemtoReg_in = 0; Branch_in = 0; MemRead_in = 0; MemWrite_in = 0;
    Jump_in = 0; jump_addr_in = 0; branch_addr_in = 0; ALU_result_in = 0;
    reg_read_data_2_in = 0; ALU_zero_in = 0; EX_MEM_RegisterRd_in = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    set_nop();
    rst = 1'b0;
    #3;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    total++; if ({RegWrite_out, MemtoReg_out} !== 2'b00) begin bad++; $display("FAIL reset_wb_ctrl got=%b exp=00", {RegWrite_out, MemtoReg_out}); end
    total++; if (read_data_out !== 32'h0 || ALU_result_out !== 32'h0 || MEM_WB_RegisterRd_out !== 5'h0) begin
      bad++; $display("FAIL reset_wb_data got=%h/%h/%h exp=0", read_data_out, ALU_result_out, MEM_WB_RegisterRd_out); end
    total++; if (Stall_out !== 1'b0 || PCSrc_out !== 1'b0) begin bad++; $display("FAIL reset_stall_pcsrc got=%b%b exp=00", Stall_out, PCSrc_out); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    int stalls;
    // ALU op: Rd=3, result 0x7, unstalled
    @(negedge clk);
    set_nop();
    RegWrite_in = 1; ALU_result_in = 32'h7; EX_MEM_RegisterRd_in = 5'd3; mem_rdata = 32'h1111;
    #1;
    total++; if (Stall_out !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b exp=0", Stall_out); end
    @(posedge clk); #1;
    total++; if (RegWrite_out !== 1'b1 || MEM_WB_RegisterRd_out !== 5'd3 || ALU_result_out !== 32'h7) begin
      bad++; $display("FAIL alu_wb got=%b/%0d/%h exp=1/3/7", RegWrite_out, MEM_WB_RegisterRd_out, ALU_result_out); end
    total++; if (read_data_out !== 32'h0) begin bad++; $display("FAIL alu_rdata got=%h exp=0", read_data_out); end
    // Load with Jump also asserted: memory access must win over redirect
    @(negedge clk);
    set_nop();
    MemRead_in = 1; RegWrite_in = 1; MemtoReg_in = 1; ALU_result_in = 32'h100;
    EX_MEM_RegisterRd_in = 5'd5; mem_rdata = 32'hDEADBEEF; Jump_in = 1; jump_addr_in = 32'h300;
    #1;
    stalls = 0;
    if (Stall_out) stalls++;
    total++; if (PCSrc_out !== 1'b0 || Flush_out !== 1'b0) begin bad++; $display("FAIL load_idle_redirect got=%b%b exp=00", PCSrc_out, Flush_out); end
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      bad++; $display("FAIL load_issue got=%b/%h/%b exp=1/100/0", mem_req, mem_addr, mem_we); end
    total++; if (RegWrite_out !== 1'b0 || MemtoReg_out !== 1'b0 || MEM_WB_RegisterRd_out !== 5'd3) begin
      bad++; $display("FAIL load_bubble1 got=%b/%b/%0d exp=0/0/3", RegWrite_out, MemtoReg_out, MEM_WB_RegisterRd_out); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      mem_ack = (k == 3);
      #1;
      if (Stall_out) stalls++;
      total++; if (PCSrc_out !== 1'b0 || Flush_out !== 1'b0) begin bad++; $display("FAIL wait_redirect k=%0d got=%b%b exp=00", k, PCSrc_out, Flush_out); end
      @(posedge clk); #1;
      if (k < 3) begin
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || RegWrite_out !== 1'b0) begin
          bad++; $display("FAIL load_wait k=%0d got=%b/%h/%b exp=1/100/0", k, mem_req, mem_addr, RegWrite_out); end
      end
    end
    total++; if (stalls !== 3) begin bad++; $display("FAIL load_stall_cycles got=%0d exp=3", stalls); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL load_req_drop got=%b exp=0", mem_req); end
    total++; if (RegWrite_out !== 1'b1 || MemtoReg_out !== 1'b1 || read_data_out !== 32'hDEADBEEF || MEM_WB_RegisterRd_out !== 5'd5) begin
      bad++; $display("FAIL load_wb got=%b/%b/%h/%0d exp=1/1/deadbeef/5", RegWrite_out, MemtoReg_out, read_data_out, MEM_WB_RegisterRd_out); end
    @(negedge clk); set_nop();
  endtask

  task automatic test_store();
    // plain store, ack in first WAIT cycle
    @(negedge clk);
    set_nop();
    MemWrite_in = 1; ALU_result_in = 32'h40; reg_read_data_2_in = 32'h12345678; mem_rdata = 32'hCAFEF00D;
    #1;
    total++; if (Stall_out !== 1'b1) begin bad++; $display("FAIL store_stall0 got=%b exp=1", Stall_out); end
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678) begin
      bad++; $display("FAIL store_issue got=%b/%b/%h/%h exp=1/1/40/12345678", mem_req, mem_we, mem_addr, mem_wdata); end
    @(negedge clk); mem_ack = 1; #1;
    total++; if (Stall_out !== 1'b0) begin bad++; $display("FAIL store_stall1 got=%b exp=0", Stall_out); end
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b0 || RegWrite_out !== 1'b0 || read_data_out !== 32'h0 || ALU_result_out !== 32'h40) begin
      bad++; $display("FAIL store_done got=%b/%b/%h/%h exp=0/0/0/40", mem_req, RegWrite_out, read_data_out, ALU_result_out); end
    // read+write together is a store
    @(negedge clk);
    set_nop();
    MemRead_in = 1; MemWrite_in = 1; RegWrite_in = 1; ALU_result_in = 32'h44;
    reg_read_data_2_in = 32'hA5A5A5A5; EX_MEM_RegisterRd_in = 5'd7; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    total++; if (mem_we !== 1'b1 || mem_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL rw_issue got=%b/%h exp=1/a5a5a5a5", mem_we, mem_wdata); end
    @(negedge clk); mem_ack = 1;
    @(posedge clk); #1;
    total++; if (read_data_out !== 32'h0 || MEM_WB_RegisterRd_out !== 5'd7) begin
      bad++; $display("FAIL rw_wb got=%h/%0d exp=0/7", read_data_out, MEM_WB_RegisterRd_out); end
    @(negedge clk); set_nop();
    // stray ack in IDLE on a non-memory op is ignored
    mem_ack = 1; mem_rdata = 32'h5A5A5A5A; RegWrite_in = 1; ALU_result_in = 32'h9; EX_MEM_RegisterRd_in = 5'd2;
    @(posedge clk); #1;
    total++; if (read_data_out !== 32'h0 || mem_req !== 1'b0 || ALU_result_out !== 32'h9) begin
      bad++; $display("FAIL idle_ack got=%h/%b/%h exp=0/0/9", read_data_out, mem_req, ALU_result_out); end
    @(negedge clk); set_nop();
  endtask

  task automatic test_branch_jump();
    @(negedge clk);
    set_nop();
    Branch_in = 1; ALU_zero_in = 1; branch_addr_in = 32'h200; jump_addr_in = 32'h300;
    #1;
    total++; if (PCSrc_out !== 1'b1 || Flush_out !== 1'b1 || PC_target_out !== 32'h200) begin
      bad++; $display("FAIL branch_taken got=%b/%b/%h exp=1/1/200", PCSrc_out, Flush_out, PC_target_out); end
    ALU_zero_in = 0; #1;
    total++; if (PCSrc_out !== 1'b0 || Flush_out !== 1'b0 || PC_target_out !== 32'h0) begin
      bad++; $display("FAIL branch_not_taken got=%b/%b/%h exp=0/0/0", PCSrc_out, Flush_out, PC_target_out); end
    ALU_zero_in = 1; Jump_in = 1; #1;
    total++; if (PCSrc_out !== 1'b1 || PC_target_out !== 32'h300) begin
      bad++; $display("FAIL jump_priority got=%b/%h exp=1/300", PCSrc_out, PC_target_out); end
    Jump_in = 0; MemRead_in = 1; #1;
    total++; if (PCSrc_out !== 1'b0 || Stall_out !== 1'b1) begin
      bad++; $display("FAIL branch_with_access got=%b/%b exp=0/1", PCSrc_out, Stall_out); end
    set_nop();
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    set_nop();
    MemRead_in = 1; RegWrite_in = 1; ALU_result_in = 32'h80; EX_MEM_RegisterRd_in = 5'd4;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstw_issue got=%b exp=1", mem_req); end
    #2 rst = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL rstw_async got=%b/%h/%b exp=0/0/0", mem_req, mem_addr, mem_we); end
    total++; if (RegWrite_out !== 1'b0 || ALU_result_out !== 32'h0 || MEM_WB_RegisterRd_out !== 5'h0 || Stall_out !== 1'b1) begin
      bad++; $display("FAIL rstw_outs got=%b/%h/%0d/%b exp=0/0/0/1", RegWrite_out, ALU_result_out, MEM_WB_RegisterRd_out, Stall_out); end
    @(negedge clk);
    rst = 1'b1;
    set_nop();
    RegWrite_in = 1; ALU_result_in = 32'h55; EX_MEM_RegisterRd_in = 5'd9;
    Branch_in = 1; ALU_zero_in = 1; branch_addr_in = 32'h200;
    mem_ack = 1; mem_rdata = 32'hAAAA;
    #1;
    total++; if (Stall_out !== 1'b0 || PCSrc_out !== 1'b1 || PC_target_out !== 32'h200) begin
      bad++; $display("FAIL rstw_release got=%b/%b/%h exp=0/1/200", Stall_out, PCSrc_out, PC_target_out); end
    @(posedge clk); #1;
    total++; if (read_data_out !== 32'h0 || MEM_WB_RegisterRd_out !== 5'd9 || RegWrite_out !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL rstw_stray_ack got=%h/%0d/%b/%b exp=0/9/1/0", read_data_out, MEM_WB_RegisterRd_out, RegWrite_out, mem_req); end
    @(negedge clk); set_nop();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_store();
    test_branch_jump();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1);
  end
endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst (rst low = reset, acting without a clock edge).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  async active-low reset.
REQ-004 RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Jump_in  input  1 each  EX/MEM control outputs.
REQ-005 jump_addr_in, branch_addr_in, ALU_result_in, reg_read_data_2_in  input  32 each  EX/MEM address/data outputs; ALU_zero_in  input  1; EX_MEM_RegisterRd_in  input  5.
REQ-006 mem_req  output  1  registered data-memory request; mem_we  output  1  1 = write; mem_addr, mem_wdata  output  32  registered address/store data.
REQ-007 mem_ack  input  1  memory completion; mem_rdata  input  32  load data, valid when mem_ack=1.
REQ-008 PCSrc_out  output  1  PC redirect; PC_target_out  output  32  redirect target; Flush_out  output  1  flush IF/ID, ID/EX, EX/MEM.
REQ-009 Stall_out  output  1  freeze PC, IF/ID, ID/EX, EX/MEM while high.
REQ-010 RegWrite_out, MemtoReg_out  output  1; read_data_out, ALU_result_out  output  32; MEM_WB_RegisterRd_out  output  5  registered MEM/WB content.

Function
REQ-011 FSM states SHALL be IDLE and WAIT.
REQ-012 access = MemRead_in | MemWrite_in; in IDLE with access=1: Stall_out=1 combinationally; next edge -> WAIT, mem_req<=1, mem_addr<=ALU_result_in, mem_wdata<=reg_read_data_2_in, mem_we<=MemWrite_in.
REQ-013 MemRead_in=MemWrite_in=1 SHALL be treated as a write (mem_we=1, read_data_out loaded 0).
REQ-014 In WAIT: Stall_out = ~mem_ack; mem_req, mem_addr, mem_wdata, mem_we held constant until ack.
REQ-015 WAIT with mem_ack=1: next edge -> IDLE, mem_req<=0, MEM/WB loads the instruction's fields, read_data_out<=mem_rdata for reads.
REQ-016 mem_ack SHALL be ignored in IDLE.
REQ-017 Minimum memory-instruction latency: 2 cycles (ack in first WAIT cycle); each extra wait cycle adds 1.
REQ-018 Non-memory instruction in IDLE: Stall_out=0; next edge MEM/WB loads RegWrite_in, MemtoReg_in, ALU_result_in, EX_MEM_RegisterRd_in, read_data_out<=0.
REQ-019 Every edge with Stall_out=1 SHALL load a bubble: RegWrite_out<=0, MemtoReg_out<=0; data fields hold.
REQ-020 Redirect evaluated only in IDLE with access=0: Jump_in=1 -> PCSrc_out=1, PC_target_out=jump_addr_in; else Branch_in&ALU_zero_in -> PCSrc_out=1, PC_target_out=branch_addr_in; else PCSrc_out=0, PC_target_out=0.
REQ-021 Jump SHALL take priority over taken branch; Branch/Jump with access=1 SHALL NOT redirect (memory access wins).
REQ-022 Flush_out SHALL equal PCSrc_out; redirect/flush outputs are combinational, same cycle as inputs.
REQ-023 PCSrc_out, Flush_out SHALL be 0 in WAIT.

Reset
REQ-024 rst low SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, and all MEM/WB outputs to 0.
REQ-025 rst low during WAIT SHALL abandon the access with no MEM/WB update; after release, Stall_out/PCSrc_out/Flush_out follow inputs combinationally per REQ-012/020.

Verification
REQ-026 Load: MemRead_in=1, RegWrite_in=1, MemtoReg_in=1, ALU_result_in=0x100, Rd=5, ack 3 cycles after mem_req rises with mem_rdata=0xDEADBEEF -> mem_addr=0x100, Stall_out high 3 cycles, then RegWrite_out=1, read_data_out=0xDEADBEEF, MEM_WB_RegisterRd_out=5; bubbles before.
REQ-027 Store: MemWrite_in=1, ALU_result_in=0x40, reg_read_data_2_in=0x12345678, ack in first WAIT cycle -> mem_we=1, mem_wdata=0x12345678, 2-cycle latency, RegWrite_out=0.
REQ-028 Branch: Branch_in=1, ALU_zero_in=1, branch_addr_in=0x200 -> PCSrc_out=Flush_out=1, PC_target_out=0x200 same cycle; ALU_zero_in=0 -> both 0.
REQ-029 Jump_in=1, jump_addr_in=0x300, Branch_in=1, ALU_zero_in=1 -> PC_target_out=0x300.
REQ-030 rst low mid-WAIT -> mem_req 0 without clock edge; all outputs 0; stray mem_ack in IDLE after release -> no MEM/WB change.
REQ-031 Back-to-back: ALU op (Rd=3, result 0x7) then load -> first appears in MEM/WB next edge unstalled, load follows REQ-026 timing.
